// File: rtl/bs_pkg.sv
// Shared definitions for the bit-serial datapath: decoder opcodes and sequencer states.
package bs_pkg;

    // Decoder opcodes. ADD ignores bit 0 (3'b10?), so test it with is_add().
    localparam logic [2:0] OP_NOP_WAIT = 3'b000;
    localparam logic [2:0] OP_NOP      = 3'b001;
    localparam logic [2:0] OP_MUL_Y    = 3'b010;
    localparam logic [2:0] OP_MUL_X    = 3'b011;
    localparam logic [2:0] OP_ADD      = 3'b100;
    localparam logic [2:0] OP_ADD_MASK = 3'b110;
    localparam logic [2:0] OP_WAIT_LOW = 3'b110;
    localparam logic [2:0] OP_LOAD_X   = 3'b111;

    // Sequencer run state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } seq_state_t;

    // True for both ADD encodings.
    function automatic logic is_add(input logic [2:0] op);
        return (op & OP_ADD_MASK) == OP_ADD;
    endfunction

endpackage

// File: rtl/prog_mem.sv
// Program memory: register array with synchronous write and asynchronous read.
// The asynchronous read lets the sequencer register mem[next_pc] straight into its
// instruction output, giving zero-bubble advances.
module prog_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 3,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are deliberately not reset; a program survives a sequencer reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction source for the bit-serial decoder: program memory, PC and an
// IDLE/RUN/HALT state machine advancing on the decoder's pc-increment strobe.
module instr_sequencer
    import bs_pkg::*;
#(
    parameter int PROG_DEPTH = 16,
    parameter int INSTR_W    = 3,
    parameter int CNT_W      = 3,
    localparam int AW        = $clog2(PROG_DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_prog_we,
    input  logic [AW-1:0]      i_prog_addr,
    input  logic [INSTR_W-1:0] i_prog_instr,
    input  logic [AW-1:0]      i_last_addr,
    input  logic               i_loop,
    input  logic               i_run,
    input  logic               i_pcincr,
    input  logic [CNT_W-1:0]   i_cur_count,
    output logic [INSTR_W-1:0] o_instr,
    output logic [CNT_W-1:0]   o_data_count,
    output logic [AW-1:0]      o_pc,
    output logic               o_running,
    output logic               o_halted
);

    localparam logic [INSTR_W-1:0] NOP_WAIT = INSTR_W'(OP_NOP_WAIT);

    seq_state_t         state_q, state_d;
    logic [AW-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;

    logic               mem_we;
    logic [AW-1:0]      rd_addr;
    logic [INSTR_W-1:0] rd_data;
    logic [AW-1:0]      pc_inc;
    logic               at_last;

    // pc+1 wraps naturally at PROG_DEPTH because the width is exactly AW.
    assign pc_inc  = pc_q + AW'(1);
    assign at_last = (pc_q == i_last_addr);

    // Single read port: the next instruction is pc+1 while mid-program, otherwise
    // entry 0 (start, restart after HALT, or loop wrap).
    assign rd_addr = ((state_q == RUN) && !at_last) ? pc_inc : '0;

    prog_mem #(
        .DEPTH (PROG_DEPTH),
        .WIDTH (INSTR_W)
    ) u_prog_mem (
        .clk_i   (i_clk),
        .we_i    (mem_we && !i_rst),
        .waddr_i (i_prog_addr),
        .wdata_i (i_prog_instr),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    // Next-state, PC, instruction and write-enable decode.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        mem_we  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (i_pcincr) begin
                    if (!at_last) begin
                        pc_d    = pc_inc;
                        instr_d = rd_data;
                    end else if (i_loop) begin
                        pc_d    = '0;
                        instr_d = rd_data;
                    end else begin
                        state_d = HALT;
                        instr_d = NOP_WAIT;
                    end
                end
            end
            default: begin
                // IDLE/HALT: decoder sees NOP-wait; memory is writable. The read of
                // mem[0] happens before any same-edge write lands.
                instr_d = NOP_WAIT;
                mem_we  = i_prog_we;
                if (i_run) begin
                    state_d = RUN;
                    pc_d    = '0;
                    instr_d = rd_data;
                end
            end
        endcase
    end

    // State registers; reset overrides run, pcincr and program writes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            instr_q <= NOP_WAIT;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign o_instr      = instr_q;
    assign o_pc         = pc_q;
    assign o_running    = (state_q == RUN);
    assign o_halted     = (state_q == HALT);
    assign o_data_count = (state_q == RUN) ? (i_cur_count + CNT_W'(1)) : '0;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a driver issues one cycle of stimulus at each
// falling edge and pushes the reference model's predicted post-edge outputs; a monitor
// pops and compares just after every rising edge.
module tb_instr_sequencer;
    import bs_pkg::*;

    localparam int DEPTH = 16;

    logic       i_clk;
    logic       i_rst;
    logic       i_prog_we;
    logic [3:0] i_prog_addr;
    logic [2:0] i_prog_instr;
    logic [3:0] i_last_addr;
    logic       i_loop;
    logic       i_run;
    logic       i_pcincr;
    logic [2:0] i_cur_count;
    logic [2:0] o_instr;
    logic [2:0] o_data_count;
    logic [3:0] o_pc;
    logic       o_running;
    logic       o_halted;

    instr_sequencer dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_prog_we    (i_prog_we),
        .i_prog_addr  (i_prog_addr),
        .i_prog_instr (i_prog_instr),
        .i_last_addr  (i_last_addr),
        .i_loop       (i_loop),
        .i_run        (i_run),
        .i_pcincr     (i_pcincr),
        .i_cur_count  (i_cur_count),
        .o_instr      (o_instr),
        .o_data_count (o_data_count),
        .o_pc         (o_pc),
        .o_running    (o_running),
        .o_halted     (o_halted)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct {
        int pc;
        int instr;
        int running;
        int halted;
        int dcount;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    // Reference model: program as an int array, run flags and PC as plain integers.
    int m_mem [DEPTH];
    bit m_run  = 1'b0;
    bit m_halt = 1'b0;
    int m_pc   = 0;
    int m_instr = 0;
    int cfg_last = 3;
    bit cfg_loop = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s txn=%0d actual=%0d required=%0d", name, txn, act, req);
        end
    endtask

    // Monitor: one scoreboard entry per clock once stimulus has started.
    initial begin
        exp_t e;
        forever begin
            @(posedge i_clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                txn++;
                $display("txn %0d pc=%0d instr=%0d run=%0d halt=%0d dcnt=%0d", txn,
                         o_pc, o_instr, o_running, o_halted, o_data_count);
                chk("pc",      int'(o_pc),         e.pc);
                chk("instr",   int'(o_instr),      e.instr);
                chk("running", int'(o_running),    e.running);
                chk("halted",  int'(o_halted),     e.halted);
                chk("dcount",  int'(o_data_count), e.dcount);
            end
        end
    end

    // Drive one cycle of inputs and predict the outputs after the coming rising edge.
    task automatic step(input bit rst, input bit we, input int addr, input int wdata,
                        input bit run, input bit pcincr, input int cur);
        exp_t e;
        bit   do_write;
        @(negedge i_clk);
        i_rst        = rst;
        i_prog_we    = we;
        i_prog_addr  = 4'(addr);
        i_prog_instr = 3'(wdata);
        i_last_addr  = 4'(cfg_last);
        i_loop       = cfg_loop;
        i_run        = run;
        i_pcincr     = pcincr;
        i_cur_count  = 3'(cur);
        do_write = 1'b0;
        if (rst) begin
            m_run = 0; m_halt = 0; m_pc = 0; m_instr = 0;
        end else if (!m_run) begin
            do_write = we;
            if (run) begin
                m_run = 1; m_halt = 0; m_pc = 0; m_instr = m_mem[0];
            end else begin
                m_instr = 0;
            end
        end else if (pcincr) begin
            if (m_pc != cfg_last) begin
                m_pc = (m_pc + 1) % DEPTH;
                m_instr = m_mem[m_pc];
            end else if (cfg_loop) begin
                m_pc = 0;
                m_instr = m_mem[0];
            end else begin
                m_run = 0; m_halt = 1; m_instr = 0;
            end
        end
        if (do_write) m_mem[addr % DEPTH] = wdata % 8;
        e.pc      = m_pc;
        e.instr   = m_instr;
        e.running = m_run;
        e.halted  = m_halt;
        e.dcount  = m_run ? (cur + 1) % 8 : 0;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, k % 8);
    endtask

    task automatic advance(input int n);
        for (int k = 0; k < n; k++) begin
            step(0, 0, 0, 0, 0, 1, 7);
            idle(1);
        end
    endtask

    initial begin
        i_rst = 1'b1; i_prog_we = 1'b0; i_prog_addr = '0; i_prog_instr = '0;
        i_last_addr = 4'd3; i_loop = 1'b0; i_run = 1'b0; i_pcincr = 1'b0;
        i_cur_count = '0;

        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 1, 5);
        // Fill the whole program memory with known random contents.
        for (int a = 0; a < DEPTH; a++) step(0, 1, a, $urandom_range(7), 0, 0, 0);

        // Straight-line program of NOPs, halt at the end.
        for (int a = 0; a < 4; a++) step(0, 1, a, OP_NOP, 0, 0, 0);
        cfg_last = 3; cfg_loop = 0;
        step(0, 0, 0, 0, 1, 0, 0);
        advance(4);
        step(0, 0, 0, 0, 0, 1, 0);          // pcincr ignored in HALT

        // Same program looping.
        cfg_loop = 1;
        step(0, 0, 0, 0, 1, 0, 0);
        advance(6);
        step(0, 0, 0, 0, 1, 1, 3);          // run ignored while running

        // Bit-count sweep in RUN, then in IDLE.
        for (int c = 0; c < 8; c++) step(0, 0, 0, 0, 0, 0, c);
        step(1, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 8; c++) step(0, 0, 0, 0, 0, 0, c);

        // Writes dropped in RUN, honoured in HALT.
        for (int a = 0; a < 4; a++) step(0, 1, a, OP_NOP, 0, 0, 0);
        cfg_loop = 0;
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 1, 2, OP_LOAD_X, 0, 0, 0);
        advance(4);
        step(0, 1, 2, OP_LOAD_X, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        advance(2);

        // Reset mid-run at pc=2; pcincr ignored afterwards.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        advance(2);
        step(1, 1, 1, OP_ADD, 1, 1, 0);     // reset beats run, pcincr and write
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);

        // Write to mem[0] in the same cycle as run: old contents issued.
        step(0, 1, 0, OP_MUL_X, 1, 0, 0);
        advance(4);
        step(0, 0, 0, 0, 1, 0, 0);

        // Full-depth loop wraps modulo PROG_DEPTH.
        step(1, 0, 0, 0, 0, 0, 0);
        cfg_last = DEPTH - 1; cfg_loop = 1;
        step(0, 0, 0, 0, 1, 0, 0);
        advance(18);

        // Decoder-like closed loop: LOAD_X, ADD, NOP_WAIT; pcincr every 8 bit-counts.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, OP_LOAD_X, 0, 0, 0);
        step(0, 1, 1, OP_ADD, 0, 0, 0);
        step(0, 1, 2, OP_NOP_WAIT, 0, 0, 0);
        cfg_last = 2; cfg_loop = 0;
        step(0, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 28; k++) step(0, 0, 0, 0, (k == 9), (k % 8 == 7), k % 8);

        // Randomised traffic, including live changes of last address and loop.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(15) == 0) begin
                cfg_last = $urandom_range(DEPTH - 1);
                cfg_loop = 1'($urandom_range(1));
            end
            step(($urandom_range(99) == 0), ($urandom_range(3) == 0),
                 $urandom_range(DEPTH - 1), $urandom_range(7),
                 ($urandom_range(15) == 0), ($urandom_range(2) == 0),
                 $urandom_range(7));
        end

        repeat (3) @(posedge i_clk);
        #2;
        chk("drain", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
